// File: rtl/yildiz_io_intc_pkg.sv
// yildiz_io_intc_pkg: shared FSM encoding and width constants for the I/O interrupt controller
package yildiz_io_intc_pkg;
  localparam int ADDR_W = 12;
  localparam int BYTE_W = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1, SERVICE = 2'd2} state_t;
endpackage

// File: rtl/yildiz_io_intc.sv
// yildiz_io_intc: INPR/OUTPR byte ports with FGI/FGO flags, interrupt enable and a vectored
// request FSM (IDLE -> PEND -> SERVICE) that latches the vector on acknowledge.
module yildiz_io_intc
  import yildiz_io_intc_pkg::*;
#(
  parameter logic [ADDR_W-1:0] IN_VEC  = 12'h010,
  parameter logic [ADDR_W-1:0] OUT_VEC = 12'h020
) (
  input  logic              clkn,
  input  logic              rstn,
  input  logic              dev_in_valid,
  input  logic [BYTE_W-1:0] dev_in_data,
  output logic              dev_in_ready,
  output logic              dev_out_valid,
  output logic [BYTE_W-1:0] dev_out_data,
  input  logic              dev_out_ready,
  input  logic              cpu_inp_rd,
  output logic [BYTE_W-1:0] cpu_inpr,
  input  logic              cpu_outp_wr,
  input  logic [BYTE_W-1:0] cpu_outp_data,
  output logic              cpu_fgi,
  output logic              cpu_fgo,
  input  logic              cpu_ien_set,
  input  logic              cpu_ien_clr,
  output logic              cpu_ien,
  output logic              irq,
  output logic [ADDR_W-1:0] irq_vec,
  input  logic              irq_ack,
  output logic              err_ovr
);
  logic              fgi, fgo, ien, outValid, errOvr;
  logic [BYTE_W-1:0] inpr, outpr;
  logic [ADDR_W-1:0] vecLatched, liveVec;
  logic              condReq;
  state_t            state;

  assign condReq = ien & (fgi | fgo);
  assign liveVec = fgi ? IN_VEC : OUT_VEC;

  always_ff @(posedge clkn or posedge rstn) begin
    if (rstn) begin
      fgi        <= 1'b0;
      fgo        <= 1'b1;
      ien        <= 1'b0;
      outValid   <= 1'b0;
      errOvr     <= 1'b0;
      inpr       <= '0;
      outpr      <= '0;
      vecLatched <= '0;
      state      <= IDLE;
    end else begin
      // dev_in_ready is ~fgi, so a device load and a CPU read never collide
      if (dev_in_valid && !fgi) begin
        inpr <= dev_in_data;
        fgi  <= 1'b1;
      end else if (cpu_inp_rd && fgi) begin
        fgi <= 1'b0;
      end
      if (cpu_outp_wr && fgo) begin
        outpr    <= cpu_outp_data;
        fgo      <= 1'b0;
        outValid <= 1'b1;
      end else if (outValid && dev_out_ready) begin
        outValid <= 1'b0;
        fgo      <= 1'b1;
      end
      if ((cpu_inp_rd && !fgi) || (cpu_outp_wr && !fgo)) errOvr <= 1'b1;
      if (cpu_ien_clr || (state == PEND && irq_ack)) ien <= 1'b0;
      else if (cpu_ien_set) ien <= 1'b1;
      case (state)
        IDLE: if (condReq) state <= PEND;
        PEND:
          if (irq_ack) begin
            state      <= SERVICE;
            vecLatched <= liveVec;
          end else if (!condReq) begin
            state <= IDLE;
          end
        SERVICE: if (cpu_ien_set) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign dev_in_ready  = ~fgi;
  assign dev_out_valid = outValid;
  assign dev_out_data  = outpr;
  assign cpu_inpr      = inpr;
  assign cpu_fgi       = fgi;
  assign cpu_fgo       = fgo;
  assign cpu_ien       = ien;
  assign err_ovr       = errOvr;
  assign irq           = state == PEND;
  assign irq_vec       = state == PEND ? liveVec : state == SERVICE ? vecLatched : '0;
endmodule

// File: tb/tb_yildiz_io_intc.sv
// tb_yildiz_io_intc: directed and randomized checks against a flag-level reference model
module tb_yildiz_io_intc;
  logic clkn = 0, rstn = 1;
  logic dev_in_valid = 0, dev_out_ready = 0, cpu_inp_rd = 0, cpu_outp_wr = 0;
  logic cpu_ien_set = 0, cpu_ien_clr = 0, irq_ack = 0;
  logic [7:0] dev_in_data = 0, cpu_outp_data = 0;
  logic dev_in_ready, dev_out_valid, cpu_fgi, cpu_fgo, cpu_ien, irq, err_ovr;
  logic [7:0] dev_out_data, cpu_inpr;
  logic [11:0] irq_vec;
  int vectors = 0, miscompares = 0;

  // reference model: flags, registers, and "waiting"/"serving" interrupt status
  bit mFgi, mFgo, mIen, mValid, mErr, waiting, serving;
  bit [7:0] mInpr, mOutpr;
  bit [11:0] mLatched;

  yildiz_io_intc dut (
    .clkn(clkn), .rstn(rstn),
    .dev_in_valid(dev_in_valid), .dev_in_data(dev_in_data), .dev_in_ready(dev_in_ready),
    .dev_out_valid(dev_out_valid), .dev_out_data(dev_out_data), .dev_out_ready(dev_out_ready),
    .cpu_inp_rd(cpu_inp_rd), .cpu_inpr(cpu_inpr),
    .cpu_outp_wr(cpu_outp_wr), .cpu_outp_data(cpu_outp_data),
    .cpu_fgi(cpu_fgi), .cpu_fgo(cpu_fgo),
    .cpu_ien_set(cpu_ien_set), .cpu_ien_clr(cpu_ien_clr), .cpu_ien(cpu_ien),
    .irq(irq), .irq_vec(irq_vec), .irq_ack(irq_ack), .err_ovr(err_ovr)
  );

  always #5 clkn = ~clkn;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mFgi = 0; mFgo = 1; mIen = 0; mValid = 0; mErr = 0; waiting = 0; serving = 0;
    mInpr = 0; mOutpr = 0; mLatched = 0;
  endtask

  task automatic checkAll(input string tag);
    chk({tag, ".ready"}, dev_in_ready, !mFgi);
    chk({tag, ".inpr"}, cpu_inpr, mInpr);
    chk({tag, ".fgi"}, cpu_fgi, mFgi);
    chk({tag, ".fgo"}, cpu_fgo, mFgo);
    chk({tag, ".ien"}, cpu_ien, mIen);
    chk({tag, ".ovalid"}, dev_out_valid, mValid);
    chk({tag, ".odata"}, dev_out_data, mOutpr);
    chk({tag, ".irq"}, irq, waiting);
    chk({tag, ".vec"}, irq_vec, waiting ? (mFgi ? 12'h010 : 12'h020) : serving ? mLatched : 12'h000);
    chk({tag, ".err"}, err_ovr, mErr);
  endtask

  // advance one clock: model next state from current inputs, then compare after the edge
  task automatic tick(input string tag);
    bit nFgi, nFgo, nIen, nValid, nErr, nWaiting, nServing, want;
    bit [7:0] nInpr, nOutpr;
    bit [11:0] nLatched;
    if (rstn) modelReset();
    else begin
      nFgi = mFgi; nFgo = mFgo; nValid = mValid; nErr = mErr; nInpr = mInpr; nOutpr = mOutpr;
      nWaiting = waiting; nServing = serving; nLatched = mLatched;
      if (dev_in_valid && !mFgi) begin nFgi = 1; nInpr = dev_in_data; end
      if (cpu_inp_rd) begin if (mFgi) nFgi = 0; else nErr = 1; end
      if (cpu_outp_wr) begin
        if (mFgo) begin nOutpr = cpu_outp_data; nFgo = 0; nValid = 1; end
        else nErr = 1;
      end
      if (mValid && dev_out_ready) begin nValid = 0; nFgo = 1; end
      nIen = cpu_ien_clr ? 0 : cpu_ien_set ? 1 : mIen;
      want = mIen && (mFgi || mFgo);
      if (waiting) begin
        if (irq_ack) begin
          nWaiting = 0; nServing = 1; nIen = 0;
          nLatched = mFgi ? 12'h010 : 12'h020;
        end else if (!want) nWaiting = 0;
      end else if (serving) begin
        if (cpu_ien_set) nServing = 0;
      end else if (want) nWaiting = 1;
      mFgi = nFgi; mFgo = nFgo; mIen = nIen; mValid = nValid; mErr = nErr;
      mInpr = nInpr; mOutpr = nOutpr; waiting = nWaiting; serving = nServing; mLatched = nLatched;
    end
    @(posedge clkn);
    #1;
    checkAll(tag);
  endtask

  task automatic idleInputs();
    dev_in_valid = 0; dev_out_ready = 0; cpu_inp_rd = 0; cpu_outp_wr = 0;
    cpu_ien_set = 0; cpu_ien_clr = 0; irq_ack = 0;
  endtask

  initial begin
    modelReset();
    repeat (2) tick("rst");
    rstn = 0;
    tick("rel");
    chk("reset.fgo", cpu_fgo, 1'b1);
    chk("reset.ready", dev_in_ready, 1'b1);
    // input path
    dev_in_valid = 1; dev_in_data = 8'hA5;
    tick("in_load");
    chk("in.inpr", cpu_inpr, 8'hA5);
    chk("in.fgi", cpu_fgi, 1'b1);
    chk("in.ready", dev_in_ready, 1'b0);
    idleInputs(); cpu_inp_rd = 1;
    tick("in_read");
    chk("rd.fgi", cpu_fgi, 1'b0);
    chk("rd.inpr", cpu_inpr, 8'hA5);
    // output path with 3 stalled cycles
    idleInputs(); cpu_outp_wr = 1; cpu_outp_data = 8'h3C;
    tick("out_wr");
    idleInputs();
    repeat (3) begin
      tick("out_stall");
      chk("stall.data", dev_out_data, 8'h3C);
      chk("stall.valid", dev_out_valid, 1'b1);
    end
    dev_out_ready = 1;
    tick("out_done");
    chk("done.valid", dev_out_valid, 1'b0);
    chk("done.fgo", cpu_fgo, 1'b1);
    // interrupt on output-empty, acknowledge, return
    idleInputs(); cpu_ien_set = 1;
    tick("ien_set");
    idleInputs();
    tick("to_pend");
    chk("pend.irq", irq, 1'b1);
    chk("pend.vec", irq_vec, 12'h020);
    irq_ack = 1;
    tick("ack");
    chk("svc.irq", irq, 1'b0);
    chk("svc.ien", cpu_ien, 1'b0);
    chk("svc.vec", irq_vec, 12'h020);
    idleInputs(); irq_ack = 1; dev_in_valid = 1; dev_in_data = 8'h5A;
    tick("svc_event");
    idleInputs(); cpu_ien_set = 1;
    tick("rti");
    chk("rti.ien", cpu_ien, 1'b1);
    idleInputs();
    tick("repend");
    chk("both.vec", irq_vec, 12'h010);
    cpu_ien_set = 1; cpu_ien_clr = 1;
    tick("setclr");
    chk("setclr.ien", cpu_ien, 1'b0);
    idleInputs();
    tick("drop");
    chk("drop.irq", irq, 1'b0);
    // overrun write and mid-transfer reset
    cpu_inp_rd = 1;
    tick("drain");
    idleInputs(); cpu_outp_wr = 1; cpu_outp_data = 8'hAA;
    tick("wr_aa");
    cpu_outp_data = 8'h11;
    tick("wr_ovr");
    chk("ovr.data", dev_out_data, 8'hAA);
    chk("ovr.err", err_ovr, 1'b1);
    idleInputs();
    tick("sticky");
    chk("sticky.err", err_ovr, 1'b1);
    dev_in_valid = 1; rstn = 1;
    #1;
    modelReset();
    checkAll("async_rst");
    tick("rst_hold");
    idleInputs(); rstn = 0;
    tick("rst_rel");
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      dev_in_valid  = ($urandom_range(3) == 0);
      dev_in_data   = 8'($urandom);
      dev_out_ready = ($urandom_range(2) == 0);
      cpu_inp_rd    = ($urandom_range(4) == 0);
      cpu_outp_wr   = ($urandom_range(4) == 0);
      cpu_outp_data = 8'($urandom);
      cpu_ien_set   = ($urandom_range(5) == 0);
      cpu_ien_clr   = ($urandom_range(9) == 0);
      irq_ack       = ($urandom_range(3) == 0);
      tick("rand");
      if (i % 97 == 96) begin
        rstn = 1;
        tick("rand_rst");
        rstn = 0;
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/yildiz_io_intc.md
YILDIZ_IO_INTC -- requirements
Module: yildiz_io_intc

Interface
REQ-001 SHALL have parameter IN_VEC, default 12'h010: interrupt vector for the input-ready source.
REQ-002 SHALL have parameter OUT_VEC, default 12'h020: interrupt vector for the output-empty source.
REQ-003 SHALL use one clock and an asynchronous, active-high reset; ports are clkn and rstn.
REQ-004 clkn  in  1  system clock, rising edge.
REQ-005 rstn  in  1  asynchronous reset, active-high.
REQ-006 dev_in_valid  in  1 / dev_in_data  in  8 / dev_in_ready  out  1  input device byte handshake.
REQ-007 dev_out_valid  out  1 / dev_out_data  out  8 / dev_out_ready  in  1  output device byte handshake.
REQ-008 cpu_inp_rd  in  1  CPU consumes INPR; cpu_inpr  out  8  INPR contents.
REQ-009 cpu_outp_wr  in  1 / cpu_outp_data  in  8  CPU writes OUTPR.
REQ-010 cpu_fgi  out  1 / cpu_fgo  out  1  input-full and output-empty flags.
REQ-011 cpu_ien_set  in  1 / cpu_ien_clr  in  1  interrupt enable control; cpu_ien  out  1.
REQ-012 irq  out  1 / irq_vec  out  12 / irq_ack  in  1  interrupt request, vector, acknowledge.
REQ-013 err_ovr  out  1  sticky error: CPU write while FGO=0 or read while FGI=0.

Function
REQ-014 Input path: dev_in_ready = ~FGI (registered); dev_in_valid&&dev_in_ready loads INPR and sets FGI at the next edge.
REQ-015 cpu_inp_rd with FGI=1 clears FGI at the next edge; INPR holds its value; with FGI=0 it is ignored and sets err_ovr.
REQ-016 Output path: cpu_outp_wr with FGO=1 loads OUTPR, clears FGO, and sets dev_out_valid at the next edge (1-cycle latency).
REQ-017 dev_out_data = OUTPR; it is held stable while dev_out_valid=1 and dev_out_ready=0.
REQ-018 dev_out_valid&&dev_out_ready clears dev_out_valid and sets FGO at the next edge.
REQ-019 cpu_outp_wr with FGO=0 is ignored (OUTPR is unchanged) and sets err_ovr.
REQ-020 err_ovr is cleared only by reset.
REQ-021 IEN: cpu_ien_set sets it and cpu_ien_clr clears it; when both are asserted in the same cycle, clr wins.
REQ-022 FSM states IDLE, PEND, SERVICE.
REQ-023 IDLE->PEND when IEN&&(FGI||FGO); irq=1 only in PEND.
REQ-024 irq_vec = IN_VEC if FGI=1, else OUT_VEC (input has priority); irq_vec is combinational in PEND.
REQ-025 PEND->IDLE when the condition drops before acknowledge (IEN cleared, or flags consumed).
REQ-026 PEND->SERVICE on irq_ack: latch irq_vec from that cycle's value and clear IEN at the same edge.
REQ-027 In SERVICE: irq=0, irq_vec holds the latched value, new flag events are recorded but do not request.
REQ-028 SERVICE->IDLE on cpu_ien_set (return from interrupt); IEN=1 after that edge.
REQ-029 irq_ack outside PEND is ignored.
REQ-030 FGI and FGO updates in the ack cycle do not affect the latched vector.

Reset
REQ-031 Reset values: FGI=0, FGO=1, IEN=0, INPR=0, OUTPR=0, dev_out_valid=0, dev_in_ready=1, irq=0, irq_vec=0, err_ovr=0, state=IDLE.
REQ-032 Reset asserted mid-handshake or mid-interrupt SHALL abort immediately to the reset values, discarding any pending byte.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding (2-bit), the address width constant (12), and the I/O byte width constant (8).
REQ-034 The block SHALL be a single module with no sub-modules; the input and output flag/register pairs are simple enough to inline.

Verification
REQ-035 Reset, then dev_in_valid with data 8'hA5 -> next cycle cpu_inpr=A5, cpu_fgi=1, dev_in_ready=0; cpu_inp_rd -> fgi=0, ready=1.
REQ-036 cpu_outp_wr with data 8'h3C, dev_out_ready=0 for 3 cycles -> dev_out_valid=1 with data 3C held stable; ready=1 -> valid=0, fgo=1.
REQ-037 IEN=1, FGO=1 after reset -> irq=1 with irq_vec=020; irq_ack -> state SERVICE, ien=0, irq=0, latched vector 020.
REQ-038 FGI and FGO both 1, IEN=1 -> irq_vec=010; cpu_ien_set and cpu_ien_clr asserted together -> IEN=0.
REQ-039 cpu_outp_wr with data 8'h11 while FGO=0 -> OUTPR unchanged and err_ovr=1 sticky; assert rstn mid-transfer -> all outputs at reset values within the same cycle.
